// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory arbiter.
//    arb_state_t : arbiter FSM state encoding (A_PRI, B_FORCE, B_LOCK)
//    MEM_READ / MEM_WRITE : DataMemRW select values driven to the memory
package mem_pkg;

   typedef enum logic [1:0] {
      A_PRI   = 2'd0,
      B_FORCE = 2'd1,
      B_LOCK  = 2'd2
   } arb_state_t;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of every bus signal around the data-memory arbiter.
//    Port A (MEM stage)  : a_req, a_rw, a_addr, a_wdata -> a_rdata, a_stall
//    Port B (loader)     : b_req, b_rw, b_addr, b_wdata, b_lock -> b_gnt, b_rdata, b_rvalid
//    Memory side         : mem_addr, mem_wdata, mem_rw -> mem_rdata
// The slave modport is the arbiter's view; master is the view of the
// requesters and the memory surrounding it.
interface dmem_arbiter_if;

   logic        a_req;
   logic        a_rw;
   logic [31:0] a_addr;
   logic [31:0] a_wdata;
   logic [31:0] a_rdata;
   logic        a_stall;

   logic        b_req;
   logic        b_rw;
   logic [31:0] b_addr;
   logic [31:0] b_wdata;
   logic        b_lock;
   logic        b_gnt;
   logic [31:0] b_rdata;
   logic        b_rvalid;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rw;
   logic [31:0] mem_rdata;

   modport slave (
      input  a_req, a_rw, a_addr, a_wdata,
      output a_rdata, a_stall,
      input  b_req, b_rw, b_addr, b_wdata, b_lock,
      output b_gnt, b_rdata, b_rvalid,
      output mem_addr, mem_wdata, mem_rw,
      input  mem_rdata
   );

   modport master (
      output a_req, a_rw, a_addr, a_wdata,
      input  a_rdata, a_stall,
      output b_req, b_rw, b_addr, b_wdata, b_lock,
      input  b_gnt, b_rdata, b_rvalid,
      input  mem_addr, mem_wdata, mem_rw,
      output mem_rdata
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for both the starvation and the lock budget.
//    clk, reset  : clock and synchronous active-high reset
//    i_inc       : count one event (ignored once the count equals LIMIT)
//    i_clr       : return to zero; wins over i_inc
//    o_atLimit   : count currently equals LIMIT
//    o_hitNext   : an increment this cycle lands exactly on LIMIT
module sat_counter #(
   parameter int WIDTH = 3,
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_atLimit,
   output logic o_hitNext
);

   logic [WIDTH-1:0] r_count;

   // Clear has priority so the owner can drop the count on the same cycle it
   // would otherwise have counted; the count parks at LIMIT once there.
   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != WIDTH'(LIMIT))) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   // o_hitNext deliberately ignores i_clr: the owner derives its clear from
   // whether the limit is being hit, so folding it in would form a loop.
   assign o_atLimit = (r_count == WIDTH'(LIMIT));
   assign o_hitNext = i_inc && (r_count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
//    clk, reset : clock and synchronous active-high reset
//    bus        : dmem_arbiter_if.slave carrying port A (MEM stage, priority),
//                 port B (loader/debug, starvation-protected, lockable) and
//                 the memory address/write-data/select/read-data signals.
// Parameters: STARVE_LIMIT denied B cycles before B is forced a slot,
//             LOCK_MAX granted B cycles allowed in one locked burst.
module dmem_arbiter
   import mem_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int LOCK_MAX     = 8
) (
   input logic           clk,
   input logic           reset,
   dmem_arbiter_if.slave bus
);

   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam int LOCK_W   = $clog2(LOCK_MAX + 1);

   arb_state_t  r_state;
   logic        r_bRvalid;
   logic [31:0] r_bRdata;

   logic w_bGnt;
   logic w_aGnt;
   logic w_starveInc;
   logic w_starveClr;
   logic w_starveAtLimit;
   logic w_starveHitNext;
   logic w_starveHit;
   logic w_lockAtLimit;
   logic w_lockHitNext;
   logic w_lockHit;
   logic w_lockNext;

   // Only A_PRI lets an active port A pre-empt B; in the forced and locked
   // states B owns the slot whenever it asks, and otherwise A gets it.
   assign w_bGnt = bus.b_req && ((r_state != A_PRI) || !bus.a_req);
   assign w_aGnt = bus.a_req && !w_bGnt;

   // B is starving while it asks and A takes the slot. The force decision is
   // taken on the edge where the count reaches the limit, so the forced slot
   // is the very next cycle.
   assign w_starveInc = bus.b_req && w_aGnt;
   assign w_starveClr = !bus.b_req || w_bGnt;
   assign w_starveHit = w_starveAtLimit || w_starveHitNext;

   // The lock counter sees every granted B cycle and is cleared whenever the
   // burst is not continuing, so the cycle that enters a lock counts as 0.
   // w_lockNext is the single "stay/enter locked" decision for all states.
   assign w_lockHit  = w_bGnt && (w_lockHitNext || w_lockAtLimit);
   assign w_lockNext = w_bGnt && bus.b_lock && !w_lockHit;

   sat_counter #(
      .WIDTH (STARVE_W),
      .LIMIT (STARVE_LIMIT)
   ) u_starveCnt (
      .clk       (clk),
      .reset     (reset),
      .i_inc     (w_starveInc),
      .i_clr     (w_starveClr),
      .o_atLimit (w_starveAtLimit),
      .o_hitNext (w_starveHitNext)
   );

   sat_counter #(
      .WIDTH (LOCK_W),
      .LIMIT (LOCK_MAX)
   ) u_lockCnt (
      .clk       (clk),
      .reset     (reset),
      .i_inc     (w_bGnt),
      .i_clr     (!w_lockNext),
      .o_atLimit (w_lockAtLimit),
      .o_hitNext (w_lockHitNext)
   );

   // Arbitration FSM. Leaving B_LOCK at the burst limit always goes through
   // A_PRI so a waiting port A is served before B can lock again.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= A_PRI;
      end else begin
         case (r_state)
            A_PRI: begin
               if (w_starveHit) begin
                  r_state <= B_FORCE;
               end else if (w_lockNext) begin
                  r_state <= B_LOCK;
               end
            end
            B_FORCE: r_state <= w_lockNext ? B_LOCK : A_PRI;
            B_LOCK:  r_state <= w_lockNext ? B_LOCK : A_PRI;
            default: r_state <= A_PRI;
         endcase
      end
   end

   // Port B reads come back one cycle later through a holding register;
   // the valid flag is a single-cycle pulse and is never raised by writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bRvalid <= 1'b0;
         r_bRdata  <= '0;
      end else begin
         r_bRvalid <= w_bGnt && (bus.b_rw == MEM_READ);
         if (w_bGnt && (bus.b_rw == MEM_READ)) begin
            r_bRdata <= bus.mem_rdata;
         end
      end
   end

   // Memory drive follows the granted port; an idle cycle presents a
   // quiet read of address 0 so no stray write can reach the memory.
   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_rw    = MEM_READ;
      if (w_bGnt) begin
         bus.mem_addr  = bus.b_addr;
         bus.mem_wdata = bus.b_wdata;
         bus.mem_rw    = bus.b_rw;
      end else if (w_aGnt) begin
         bus.mem_addr  = bus.a_addr;
         bus.mem_wdata = bus.a_wdata;
         bus.mem_rw    = bus.a_rw;
      end
   end

   assign bus.a_rdata  = bus.mem_rdata;
   assign bus.a_stall  = bus.a_req && !w_aGnt;
   assign bus.b_gnt    = w_bGnt;
   assign bus.b_rdata  = r_bRdata;
   assign bus.b_rvalid = r_bRvalid;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between two requesters: the pipeline MEM stage (port A, latency-critical) and a loader/debug port (port B, used for program/data load and memory inspection). Port A has priority, and port B is protected from starvation by a bounded-wait counter. Port B may lock the memory for short multi-word bursts. The block sits between the MEM stage and the data memory and drives the memory's address, write-data and read/write-select inputs.

## Interface
- STARVE_LIMIT, 4: consecutive cycles port B may be denied before it is forced a slot (≥1).
- LOCK_MAX, 8: maximum consecutive cycles port B may hold the memory under lock (≥1).
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  MEM stage requests a memory access this cycle.
- a_rw  in  1  1 = write, 0 = read (DataMemRW encoding).
- a_addr  in  32  byte address (ALU result).
- a_wdata  in  32  store data.
- a_rdata  out  32  read data, combinational pass-through of mem_rdata.
- a_stall  out  1  port A not served this cycle; the pipeline must hold.
- b_req, b_rw, b_addr[32], b_wdata[32]  in  port B request, same encoding as port A.
- b_lock  in  1  port B requests to keep the grant next cycle.
- b_gnt  out  1  port B served this cycle.
- b_rdata  out  32  registered read data.
- b_rvalid  out  1  b_rdata valid; one-cycle pulse.
- mem_addr  out  32  to data memory.
- mem_wdata  out  32  to data memory.
- mem_rw  out  1  to data memory; 1 = write. Forced to 0 when no grant.
- mem_rdata  in  32  from data memory; asynchronous read.

## Operation
- FSM states: A_PRI, B_FORCE, B_LOCK. Reset state is A_PRI.
- Grant is combinational from state and requests.
  - A_PRI: grant A if a_req; else grant B if b_req; else no grant.
  - B_FORCE: grant B if b_req; otherwise grant A (no stall).
  - B_LOCK: grant B if b_req; otherwise grant A.
- a_stall = a_req && !(grant==A). mem_* come from the granted port. With no grant, mem_addr/mem_wdata = 0 and mem_rw = 0.
- Starvation counter (width ⌈log2(STARVE_LIMIT+1)⌉):
  - Increments when b_req && grant==A.
  - Clears whenever B is granted or b_req is low.
  - Saturates at STARVE_LIMIT.
  - When it reaches STARVE_LIMIT, the next state is B_FORCE.
- Transitions:
  - A_PRI → B_FORCE on counter==STARVE_LIMIT. A_PRI → B_LOCK if B granted && b_lock. Otherwise stay in A_PRI.
  - B_FORCE → B_LOCK if B granted && b_lock. Otherwise → A_PRI.
  - B_LOCK → A_PRI when !b_req, !b_lock, or the lock counter reaches LOCK_MAX-1 on a granted cycle.
- Lock counter:
  - Counts granted B cycles from lock entry, counting the entry cycle as 0.
  - Clears on leaving B_LOCK.
  - Exiting at the limit is mandatory even if b_lock stays high. The FSM then returns to A_PRI, so A is granted first if a_req is high.
- b_rvalid/b_rdata:
  - On a granted B read, b_rdata ← mem_rdata at the clock edge, and b_rvalid=1 for the following cycle.
  - B writes do not raise b_rvalid.
  - b_rdata holds its last value otherwise.
- Writes commit at the clock edge of the granted cycle (memory behaviour). A write that is not granted never reaches memory.

## Timing
- Reset values: state A_PRI, both counters 0, b_rvalid 0, b_rdata 0. Combinational outputs follow from that state.
- Port A read latency: 0 cycles (same cycle as grant). Port B read latency: 1 cycle.
- Reset asserted mid-lock or mid-force: the next cycle is in A_PRI with counters cleared, and b_rvalid is 0 even if a B read was granted in the reset cycle.
- Simultaneous a_req and b_req in A_PRI with counter < STARVE_LIMIT: A wins and the counter increments.
- b_req dropping in B_FORCE: the slot goes to A and the state returns to A_PRI. The forced slot is not held idle.
- a_stall never depends on a_rw. Reads and writes are arbitrated identically.

## Structure
- Shared package/header (`mem_pkg`): state encodings (A_PRI=2'd0, B_FORCE=2'd1, B_LOCK=2'd2) and the MEM_READ=0 / MEM_WRITE=1 constants used by DataMemRW.
- One natural sub-module, `sat_counter`: parameterized width/limit, with inc, clr and at_limit signals. It is instantiated twice, once for starvation and once for lock.
- The top level contains only the FSM, the grant mux and the B read-data register.

## Test plan
- Reset: hold reset 2 cycles with a_req=b_req=1. Required: b_rvalid=0 and b_rdata=0; after release the first cycle grants A (a_stall=0, b_gnt=0).
- Starvation: a_req and b_req both held high, STARVE_LIMIT=4. Required: A is granted cycles 0–3, cycle 4 has b_gnt=1 and a_stall=1, and cycle 5 grants A again.
- B read: b_req=1, b_rw=0, b_addr=0x10, a_req=0, memory[0x10]=0xDEADBEEF. Required: b_gnt=1 in cycle 0; b_rvalid=1 and b_rdata=0xDEADBEEF in cycle 1.
- Lock limit: b_lock=1, b_req=1, a_req=1, LOCK_MAX=8, entered through a forced slot. Required: exactly 8 consecutive b_gnt cycles, then A is granted.
- Write isolation: a_rw=1 to 0x20 with data 0x1234 is stalled by a forced B slot and retried the next cycle. Required: memory[0x20] is written exactly once, with value 0x1234, on the retry edge; mem_rw=0 on idle cycles.
